// File: rtl/dsp_pattern_factor_gen.sv
// dsp_pattern_factor_gen
// Finds every operand pair (a, b) with a * b == target by trial division over
// b = 1, 2, 3, ... using a bit-serial restoring divider. Each exact pair whose
// quotient fits the signed a operand is offered on a valid/ready interface.
module dsp_pattern_factor_gen #(
   parameter int TGT_W = 44,
   parameter int A_W   = 27,
   parameter int B_W   = 18,
   parameter int B_MAX = 131071
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [TGT_W-1:0] target_i,
   input  logic             first_only_i,
   output logic [A_W-1:0]   a_o,
   output logic [B_W-1:0]   b_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [B_W-1:0]   pairs_o
);

   // Remainder is always < b, so one extra bit absorbs the shift-in.
   localparam int               REM_W     = B_W + 1;
   localparam int               CNT_W     = $clog2(TGT_W);
   localparam logic [B_W-1:0]   B_LIMIT   = B_W'(B_MAX);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(TGT_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DIV,
      S_CHECK,
      S_EMIT,
      S_FIN
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [TGT_W-1:0]       tgt_q;
   logic                   first_only_q;
   logic [B_W-1:0]         b_q;
   logic [REM_W-1:0]       rem_q;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB,
   // so after TGT_W steps this register holds the full quotient.
   logic [TGT_W-1:0]       dvd_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [A_W-1:0]         a_q;
   logic [B_W-1:0]         b_out_q;
   logic [B_W-1:0]         pairs_q;
   logic [REM_W+TGT_W-1:0] step;
   logic                   out_of_range;
   logic                   emit_ok;

   // One restoring division step: returns {next remainder, next dividend/quotient}.
   function automatic logic [REM_W+TGT_W-1:0] div_step(
      input logic [REM_W-1:0] rem,
      input logic [TGT_W-1:0] dvd,
      input logic [B_W-1:0]   divisor
   );
      logic [REM_W-1:0] trial;
      logic [REM_W-1:0] dext;
      trial = {rem[REM_W-2:0], dvd[TGT_W-1]};
      dext  = REM_W'(divisor);
      if (trial >= dext) begin
         return {trial - dext, dvd[TGT_W-2:0], 1'b1};
      end
      return {trial, dvd[TGT_W-2:0], 1'b0};
   endfunction

   assign step = div_step(rem_q, dvd_q, b_q);

   // The bound check runs before any division, so b never has to wrap.
   assign out_of_range = (b_q > B_LIMIT) || (TGT_W'(b_q) > tgt_q);

   // Exact factor whose quotient fits a non-negative signed A_W operand.
   assign emit_ok = (rem_q == '0) && (dvd_q != '0) && (dvd_q[TGT_W-1:A_W-1] == '0);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = (target_i == '0) ? S_FIN : S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = out_of_range ? S_FIN : S_DIV;
         end
         S_DIV: begin
            if (cnt_q == LAST_STEP) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d = emit_ok ? S_EMIT : S_LOAD;
         end
         S_EMIT: begin
            if (ready_i) begin
               state_d = first_only_q ? S_FIN : S_LOAD;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      valid_o = (state_q == S_EMIT);
      busy_o  = (state_q == S_LOAD) || (state_q == S_DIV) ||
                (state_q == S_CHECK) || (state_q == S_EMIT);
      done_o  = (state_q == S_FIN);
   end

   // Target latch, candidate divisor, divider datapath and emitted pair.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tgt_q        <= '0;
         first_only_q <= 1'b0;
         b_q          <= '0;
         rem_q        <= '0;
         dvd_q        <= '0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_out_q      <= '0;
         pairs_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  tgt_q        <= target_i;
                  first_only_q <= first_only_i;
                  b_q          <= B_W'(1);
                  pairs_q      <= '0;
               end
            end
            S_LOAD: begin
               rem_q <= '0;
               dvd_q <= tgt_q;
               cnt_q <= '0;
            end
            S_DIV: begin
               rem_q <= step[REM_W+TGT_W-1:TGT_W];
               dvd_q <= step[TGT_W-1:0];
               cnt_q <= cnt_q + CNT_W'(1);
            end
            S_CHECK: begin
               if (emit_ok) begin
                  a_q     <= dvd_q[A_W-1:0];
                  b_out_q <= b_q;
               end else begin
                  b_q <= b_q + B_W'(1);
               end
            end
            S_EMIT: begin
               if (ready_i) begin
                  pairs_q <= pairs_q + B_W'(1);
                  if (!first_only_q) begin
                     b_q <= b_q + B_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign a_o     = a_q;
   assign b_o     = b_out_q;
   assign pairs_o = pairs_q;

endmodule

// File: tb/tb_dsp_pattern_factor_gen.sv
// tb_dsp_pattern_factor_gen
// Directed bench for the factor-pair generator: table of complete searches
// plus hand-written sequences for back-pressure, reset abort, quotient
// overflow and the B_MAX bound (on a narrow second instance).
module tb_dsp_pattern_factor_gen;

   localparam int TGT_W = 44;
   localparam int A_W   = 27;
   localparam int B_W   = 18;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [TGT_W-1:0] target;
   logic             first_only;
   logic [A_W-1:0]   a;
   logic [B_W-1:0]   b;
   logic             valid;
   logic             ready;
   logic             busy;
   logic             done;
   logic [B_W-1:0]   pairs;

   // Narrow instance so the B_MAX bound is reachable in a short run.
   logic             s_start;
   logic [15:0]      s_target;
   logic             s_first_only;
   logic [8:0]       s_a;
   logic [5:0]       s_b;
   logic             s_valid;
   logic             s_ready;
   logic             s_busy;
   logic             s_done;
   logic [5:0]       s_pairs;

   int n_tests = 0;
   int n_fail  = 0;

   int s_exp_a [6] = '{250, 200, 125, 100, 50, 40};
   int s_exp_b [6] = '{4, 5, 8, 10, 20, 25};

   typedef struct packed {
      logic [TGT_W-1:0]       target;
      logic                   first_only;
      logic [3:0]             npairs;
      logic [5:0][A_W-1:0]    exp_a;
      logic [5:0][B_W-1:0]    exp_b;
      logic [15:0]            first_lat;
      logic [15:0]            done_lat;
   } vec_t;

   vec_t vecs [5];

   dsp_pattern_factor_gen dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .target_i     (target),
      .first_only_i (first_only),
      .a_o          (a),
      .b_o          (b),
      .valid_o      (valid),
      .ready_i      (ready),
      .busy_o       (busy),
      .done_o       (done),
      .pairs_o      (pairs)
   );

   dsp_pattern_factor_gen #(
      .TGT_W (16),
      .A_W   (9),
      .B_W   (6),
      .B_MAX (31)
   ) dut_small (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (s_start),
      .target_i     (s_target),
      .first_only_i (s_first_only),
      .a_o          (s_a),
      .b_o          (s_b),
      .valid_o      (s_valid),
      .ready_i      (s_ready),
      .busy_o       (s_busy),
      .done_o       (s_done),
      .pairs_o      (s_pairs)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; target = '0; first_only = 1'b0; ready = 1'b0;
      s_start = 1'b0; s_target = '0; s_first_only = 1'b0; s_ready = 1'b1;

      // Vector table: complete searches with ready tied high.
      vecs[0] = '0;
      vecs[0].target = 44'd12; vecs[0].npairs = 4'd6;
      vecs[0].exp_a = {27'd1, 27'd2, 27'd3, 27'd4, 27'd6, 27'd12};
      vecs[0].exp_b = {18'd12, 18'd6, 18'd4, 18'd3, 18'd2, 18'd1};
      vecs[0].first_lat = 16'd47; vecs[0].done_lat = 16'd560;

      vecs[1] = '0;
      vecs[1].target = 44'd13; vecs[1].npairs = 4'd2;
      vecs[1].exp_a = {27'd0, 27'd0, 27'd0, 27'd0, 27'd1, 27'd13};
      vecs[1].exp_b = {18'd0, 18'd0, 18'd0, 18'd0, 18'd13, 18'd1};
      vecs[1].first_lat = 16'd47; vecs[1].done_lat = 16'd602;

      vecs[2] = '0;
      vecs[2].target = 44'd0; vecs[2].npairs = 4'd0;
      vecs[2].done_lat = 16'd1;

      vecs[3] = '0;
      vecs[3].target = 44'd12; vecs[3].first_only = 1'b1; vecs[3].npairs = 4'd1;
      vecs[3].exp_a = {27'd0, 27'd0, 27'd0, 27'd0, 27'd0, 27'd12};
      vecs[3].exp_b = {18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd1};
      vecs[3].first_lat = 16'd47; vecs[3].done_lat = 16'd48;

      vecs[4] = '0;
      vecs[4].target = 44'd6; vecs[4].npairs = 4'd4;
      vecs[4].exp_a = {27'd0, 27'd0, 27'd1, 27'd2, 27'd3, 27'd6};
      vecs[4].exp_b = {18'd0, 18'd0, 18'd6, 18'd3, 18'd2, 18'd1};
      vecs[4].first_lat = 16'd47; vecs[4].done_lat = 16'd282;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset a_o", a, 0);
      check("reset b_o", b, 0);
      check("reset valid_o", valid, 0);
      check("reset busy_o", busy, 0);
      check("reset done_o", done, 0);
      check("reset pairs_o", pairs, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle busy_o", busy, 0);

      // Table-driven searches
      for (int v = 0; v < 5; v++) begin
         int  got;
         int  first_k;
         int  done_k;
         bit  fin;
         got = 0; first_k = 0; done_k = 0; fin = 1'b0;
         ready = 1'b1; start = 1'b1;
         target = vecs[v].target; first_only = vecs[v].first_only;
         for (int k = 1; k <= 2000 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) begin
               if (got == 0) first_k = k;
               if (got < int'(vecs[v].npairs)) begin
                  check($sformatf("vec%0d pair%0d a_o", v, got), a, vecs[v].exp_a[got]);
                  check($sformatf("vec%0d pair%0d b_o", v, got), b, vecs[v].exp_b[got]);
               end else begin
                  fail_now($sformatf("vec%0d unexpected pair a=%0d b=%0d", v, a, b));
               end
               got++;
            end
            if (done) begin
               fin = 1'b1;
               done_k = k;
            end
         end
         if (!fin) begin
            fail_now($sformatf("vec%0d timeout waiting for done_o", v));
         end else begin
            check($sformatf("vec%0d pair count", v), got, vecs[v].npairs);
            check($sformatf("vec%0d pairs_o at done", v), pairs, vecs[v].npairs);
            check($sformatf("vec%0d done latency", v), done_k, vecs[v].done_lat);
            if (vecs[v].npairs != 0)
               check($sformatf("vec%0d first valid latency", v), first_k, vecs[v].first_lat);
            @(negedge clk);
            check($sformatf("vec%0d pairs_o holds", v), pairs, vecs[v].npairs);
            check($sformatf("vec%0d done_o one cycle", v), done, 0);
            check($sformatf("vec%0d busy_o after done", v), busy, 0);
         end
         @(negedge clk);
      end

      // Back-pressure: hold ready low for 20 cycles on the first pair
      begin
         bit found;
         int held;
         found = 1'b0; held = 0;
         ready = 1'b0; start = 1'b1; target = 44'd12; first_only = 1'b0;
         for (int k = 1; k <= 100 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) found = 1'b1;
         end
         if (!found) begin
            fail_now("stall timeout waiting for first valid_o");
         end else begin
            for (int i = 0; i < 20; i++) begin
               if (i > 0) @(negedge clk);
               if (valid && a == 27'd12 && b == 18'd1 && pairs == 18'd0) held++;
            end
            check("stall cycles held stable", held, 20);
            ready = 1'b1;
            @(negedge clk);
            check("stall valid_o drops after handshake", valid, 0);
            check("stall pairs_o after handshake", pairs, 1);
            found = 1'b0;
            for (int k = 1; k <= 100 && !found; k++) begin
               @(negedge clk);
               if (valid) found = 1'b1;
            end
            if (!found) begin
               fail_now("stall timeout waiting for second valid_o");
            end else begin
               check("stall second a_o", a, 6);
               check("stall second b_o", b, 2);
            end
            found = 1'b0;
            for (int k = 1; k <= 1000 && !found; k++) begin
               @(negedge clk);
               if (done) found = 1'b1;
            end
            if (!found) fail_now("stall timeout waiting for done_o");
            else check("stall pairs_o at done", pairs, 6);
         end
         @(negedge clk);
      end

      // Start while busy is ignored; async reset during the second candidate
      begin
         bit found;
         int dones;
         found = 1'b0; dones = 0;
         ready = 1'b1; start = 1'b1; target = 44'd12; first_only = 1'b0;
         for (int k = 1; k <= 100 && !found; k++) begin
            @(negedge clk);
            start = (k == 10);
            if (k == 10) begin
               target = 44'd7;
               first_only = 1'b1;
            end
            if (valid) found = 1'b1;
         end
         start = 1'b0;
         if (!found) begin
            fail_now("abort timeout waiting for first valid_o");
         end else begin
            check("abort first a_o keeps target", a, 12);
            check("abort first b_o", b, 1);
            repeat (13) @(negedge clk);
            check("abort busy in second candidate", busy, 1);
            #2 rst = 1'b1;
            #1;
            check("abort async a_o", a, 0);
            check("abort async b_o", b, 0);
            check("abort async valid_o", valid, 0);
            check("abort async busy_o", busy, 0);
            check("abort async pairs_o", pairs, 0);
            for (int i = 0; i < 3; i++) begin
               if (done) dones++;
               @(negedge clk);
            end
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               if (done) dones++;
            end
            check("abort no done_o pulse", dones, 0);
            check("abort idle after reset", busy, 0);
         end
      end

      // Quotient overflow: target 2^30 skips b=1..31
      begin
         int got;
         int first_k;
         got = 0; first_k = 0;
         ready = 1'b1; start = 1'b1; target = 44'd1 << 30; first_only = 1'b0;
         for (int k = 1; k <= 4000 && got < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) begin
               if (got == 0) begin
                  first_k = k;
                  check("pow2 first a_o", a, 64'd1 << 25);
                  check("pow2 first b_o", b, 32);
               end else begin
                  check("pow2 second a_o", a, 64'd1 << 24);
                  check("pow2 second b_o", b, 64);
               end
               got++;
            end
         end
         if (got < 2) fail_now("pow2 timeout waiting for pairs");
         else check("pow2 first valid latency", first_k, 1473);
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
      end

      // B_MAX bound on the narrow instance: (25,40) lies beyond b=31
      begin
         int  got;
         bit  fin;
         got = 0; fin = 1'b0;
         s_start = 1'b1; s_target = 16'd1000;
         for (int k = 1; k <= 1500 && !fin; k++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_valid) begin
               if (got < 6) begin
                  check($sformatf("bmax pair%0d a_o", got), s_a, s_exp_a[got]);
                  check($sformatf("bmax pair%0d b_o", got), s_b, s_exp_b[got]);
               end else begin
                  fail_now($sformatf("bmax unexpected pair a=%0d b=%0d", s_a, s_b));
               end
               got++;
            end
            if (s_done) fin = 1'b1;
         end
         if (!fin) begin
            fail_now("bmax timeout waiting for done_o");
         end else begin
            check("bmax pair count", got, 6);
            check("bmax pairs_o at done", s_pairs, 6);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
